adder_result_checker: RTL
=========================

// Module: adder_result_checker
// PURPOSE
//  Response-side checker for the ripple-carry adder fault-injection flow: accepts one
//  {A, B, CIN, observed SUM} record per handshake, recomputes the golden sum, and
//  reports pass/fail, bit-level error syndrome and lowest faulty bit position.
//  Keeps running test/fail counts. Sits downstream of the adder under test, consuming
//  what the stimulus side drives.
// PARAMETERS
//  WIDTH    8   operand width; observed/golden sum is WIDTH+1 bits (carry-out at MSB)
//  CNT_W    16  width of test_count / fail_count
//  IDX_W    4   width of res_bit_idx; must satisfy 2**IDX_W > WIDTH
// PORTS
//  clk          in   1        single clock, all state on rising edge
//  rst          in   1        synchronous, active-high reset
//  in_valid     in   1        input record valid
//  in_ready     out  1        checker can accept a record
//  in_a         in   WIDTH    operand A
//  in_b         in   WIDTH    operand B
//  in_cin       in   1        carry-in
//  in_sum       in   WIDTH+1  sum observed from the adder under test
//  res_valid    out  1        result record valid
//  res_ready    in   1        downstream accepts result
//  res_fail     out  1        1 = observed != golden
//  res_syndrome out  WIDTH+1  golden XOR observed
//  res_bit_idx  out  IDX_W    index of lowest set syndrome bit; 0 when res_fail=0
//  test_count   out  CNT_W    records checked (counted at result accept)
//  fail_count   out  CNT_W    records failed (counted at result accept)
//  fault_map    out  WIDTH+1  sticky OR of syndromes (see CONFIGURATION)
// BEHAVIOUR
//  - FSM: IDLE -> CALC -> HOLD -> IDLE. in_ready = (state==IDLE).
//  - IDLE: on in_valid&&in_ready, register a/b/cin/sum; go CALC.
//  - CALC (1 cycle): golden = {1'b0,a}+{1'b0,b}+cin, unsigned, WIDTH+1 bits, no
//    truncation; syndrome = golden^sum; fail = |syndrome; bit_idx by lowest-set
//    priority scan (bit 0 highest priority). Register all results; go HOLD.
//  - HOLD: res_valid=1, outputs stable until res_valid&&res_ready; on that cycle
//    test_count+=1, fail_count+=res_fail, then IDLE. Stalls indefinitely without ready.
//  - Latency: input accepted cycle N -> res_valid asserted cycle N+2. Max throughput
//    one record per 3 cycles (res_ready held high).
//  - in_valid while not in IDLE is ignored (no capture; source must hold).
//  - Counters saturate at all-ones; fail_count saturates independently.
//  - X/Z on in_sum is not checked; bench drives known values only.
//  - Reset (any state, incl. mid-CALC/HOLD): state=IDLE, in_ready=1 after reset
//    deasserts, res_valid=0, res_fail=0, res_syndrome=0, res_bit_idx=0, test_count=0,
//    fail_count=0, fault_map=0; pending record is dropped and not counted.
// CONFIGURATION
//  - Macro FAULT_MAP_EN: when defined, fault_map |= res_syndrome at each result
//    accept with res_fail=1; cleared only by rst. Identifies every stuck/incorrect
//    bit seen across a run.
//  - Not defined: fault_map tied to 0; no accumulation register synthesised.
// TESTING
//  - A=200,B=100,CIN=1,SUM=301 -> res_valid at N+2, fail=0, syndrome=0, idx=0, test_count=1.
//  - A=200,B=100,CIN=1,SUM=300 (bit0 fault) -> fail=1, syndrome=9'h001, idx=0, fail_count=1.
//  - A=255,B=255,CIN=1,SUM=511 -> pass; then SUM=255 -> syndrome=9'h100, idx=8.
//  - Hold res_ready=0 for 10 cycles in HOLD -> outputs stable, in_ready=0, counts unchanged,
//    new in_valid ignored; release -> counts +1 once.
//  - Assert rst during HOLD -> next cycle res_valid=0, counts=0, in_ready=1.
//  - FAULT_MAP_EN: failures with syndromes 9'h001 then 9'h010 -> fault_map=9'h011;
//    without macro fault_map=0 throughout.

Source files
------------

// File: rtl/adder_result_checker.sv
// Recomputes the golden sum for each {A,B,CIN,SUM} record and reports pass/fail, syndrome and lowest faulty bit.
// Result appears two cycles after accept and is held until accepted downstream; optional FAULT_MAP_EN accumulates a sticky fault map.
module adder_result_checker #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [WIDTH:0]   in_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_fail,
  output logic [WIDTH:0]   res_syndrome,
  output logic [IDX_W-1:0] res_bit_idx,
  output logic [CNT_W-1:0] test_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [WIDTH:0]   fault_map
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t             state_q;
  logic               in_ready_q;
  logic               res_valid_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               cin_q;
  logic [WIDTH:0]     sum_q;
  logic               res_fail_q;
  logic [WIDTH:0]     res_syndrome_q;
  logic [IDX_W-1:0]   res_bit_idx_q;
  logic [CNT_W-1:0]   test_count_q;
  logic [CNT_W-1:0]   fail_count_q;

  logic [WIDTH:0]     golden_d;
  logic [WIDTH:0]     syndrome_d;
  logic               fail_d;
  logic [IDX_W-1:0]   bit_idx_d;
  logic               res_accept;

  // Operands are zero-extended so the carry-out lands in the MSB of the golden sum.
  always_comb begin
    golden_d   = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);
    syndrome_d = golden_d ^ sum_q;
    fail_d     = |syndrome_d;
    bit_idx_d  = '0;
    for (int i = WIDTH; i >= 0; i--) begin
      if (syndrome_d[i]) bit_idx_d = IDX_W'(i);
    end
  end

  assign res_accept = res_valid_q && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b1;
      res_valid_q    <= 1'b0;
      a_q            <= '0;
      b_q            <= '0;
      cin_q          <= 1'b0;
      sum_q          <= '0;
      res_fail_q     <= 1'b0;
      res_syndrome_q <= '0;
      res_bit_idx_q  <= '0;
      test_count_q   <= '0;
      fail_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= in_a;
            b_q        <= in_b;
            cin_q      <= in_cin;
            sum_q      <= in_sum;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          res_fail_q     <= fail_d;
          res_syndrome_q <= syndrome_d;
          res_bit_idx_q  <= bit_idx_d;
          res_valid_q    <= 1'b1;
          state_q        <= HOLD;
        end
        HOLD: begin
          if (res_accept) begin
            if (test_count_q != '1) test_count_q <= test_count_q + CNT_W'(1);
            if (res_fail_q && (fail_count_q != '1)) fail_count_q <= fail_count_q + CNT_W'(1);
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

`ifdef FAULT_MAP_EN
  logic [WIDTH:0] fault_map_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_map_q <= '0;
    end else if (res_accept && res_fail_q) begin
      fault_map_q <= fault_map_q | res_syndrome_q;
    end
  end

  assign fault_map = fault_map_q;
`else
  assign fault_map = '0;
`endif

  assign in_ready     = in_ready_q;
  assign res_valid    = res_valid_q;
  assign res_fail     = res_fail_q;
  assign res_syndrome = res_syndrome_q;
  assign res_bit_idx  = res_bit_idx_q;
  assign test_count   = test_count_q;
  assign fail_count   = fail_count_q;

endmodule
